// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate datapath: FSM states,
// default widths and the saturating adder used by the accumulator stage.
package mac_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int PW_DEF = 8;
  localparam int AW_DEF = 12;

  // Working width of sat_add; callers sign-extend into it and keep the low AW bits.
  localparam int SAT_W = 32;

  typedef struct packed {
    logic             ovf;
    logic [SAT_W:0]   sum;
  } sat_res_t;

  // Adds two sign-extended operands and clamps the result to the signed
  // range of an aw-bit accumulator, flagging when clamping occurred.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] acc,
                                       input logic signed [SAT_W-1:0] sext_prod,
                                       input int unsigned             aw);
    logic signed [SAT_W:0] sum_s;
    logic signed [SAT_W:0] max_s;
    logic signed [SAT_W:0] min_s;
    sat_res_t              res;
    sum_s = {acc[SAT_W-1], acc} + {sext_prod[SAT_W-1], sext_prod};
    max_s = (33'sd1 <<< (aw - 32'd1)) - 33'sd1;
    min_s = -(33'sd1 <<< (aw - 32'd1));
    if (sum_s > max_s) begin
      res.ovf = 1'b1;
      res.sum = max_s;
    end else if (sum_s < min_s) begin
      res.ovf = 1'b1;
      res.sum = min_s;
    end else begin
      res.ovf = 1'b0;
      res.sum = sum_s;
    end
    return res;
  endfunction

endpackage

// File: rtl/prod_accum.sv
// Saturating accumulator: sums N signed products per result and presents the
// result on a valid/ready port; input is stalled while a result is pending.
module prod_accum
  import mac_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int AW = AW_DEF,
  parameter int N  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_sat
);

  localparam int CW = $clog2(N + 1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] acc_r;
  logic [AW-1:0] acc_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          sat_r;
  logic          sat_nxt_s;
  logic [AW-1:0] sum_nxt_s;
  logic          osat_nxt_s;
  logic          in_acc_s;
  logic          out_acc_s;
  logic          last_s;
  sat_res_t      add_s;
  logic          unused_s;

  assign add_s = sat_add({{(SAT_W - AW){acc_r[AW-1]}}, acc_r},
                         {{(SAT_W - PW){in_prod[PW-1]}}, in_prod},
                         AW);
  // After clamping the bits above AW are pure sign extension.
  assign unused_s  = ^add_s.sum[SAT_W:AW];
  assign in_acc_s  = in_valid & in_ready;
  assign out_acc_s = out_valid & out_ready;
  assign last_s    = (cnt_r == CW'(N - 1));

  // Next-state, accumulator update and result load.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    sat_nxt_s   = sat_r;
    sum_nxt_s   = out_sum;
    osat_nxt_s  = out_sat;
    case (state_r)
      ACC: begin
        if (in_acc_s) begin
          acc_nxt_s = add_s.sum[AW-1:0];
          cnt_nxt_s = cnt_r + CW'(1);
          sat_nxt_s = sat_r | add_s.ovf;
          if (last_s) begin
            state_nxt_s = HOLD;
            sum_nxt_s   = add_s.sum[AW-1:0];
            osat_nxt_s  = sat_r | add_s.ovf;
          end else begin
            state_nxt_s = ACC;
          end
        end else begin
          state_nxt_s = ACC;
        end
      end
      HOLD: begin
        if (out_acc_s) begin
          state_nxt_s = ACC;
          acc_nxt_s   = '0;
          cnt_nxt_s   = '0;
          sat_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = ACC;
        acc_nxt_s   = '0;
        cnt_nxt_s   = '0;
        sat_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, datapath and handshake outputs; handshakes decode the next state so
  // in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ACC;
      acc_r     <= '0;
      cnt_r     <= '0;
      sat_r     <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      acc_r     <= acc_nxt_s;
      cnt_r     <= cnt_nxt_s;
      sat_r     <= sat_nxt_s;
      out_sum   <= sum_nxt_s;
      out_sat   <= osat_nxt_s;
      in_ready  <= (state_nxt_s == ACC);
      out_valid <= (state_nxt_s == HOLD);
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: three configurations (default, AW=9, N=1) driven by
// directed and random traffic, checked against an integer reference model.
module tb_prod_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv[3];
  logic [7:0] ip[3];
  logic       ordy[3];
  logic       rdy[3];
  logic       vld[3];
  logic       osat[3];
  logic [11:0] sum0;
  logic [8:0]  sum1;
  logic [11:0] sum2;

  int checks = 0;
  int errors = 0;

  // reference model state, one entry per DUT
  int aw_l[3] = '{12, 9, 12};
  int n_l[3]  = '{4, 4, 1};
  int acc_m[3];
  int cnt_m[3];
  int sum_m[3];
  bit sat_m[3];
  bit hold_m[3];
  bit osat_m[3];

  int obs_sum[3];

  always #5 clk = ~clk;

  prod_accum #(.PW(8), .AW(12), .N(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .in_prod(ip[0]),
    .out_valid(vld[0]), .out_ready(ordy[0]), .out_sum(sum0), .out_sat(osat[0]));

  prod_accum #(.PW(8), .AW(9), .N(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]), .in_prod(ip[1]),
    .out_valid(vld[1]), .out_ready(ordy[1]), .out_sum(sum1), .out_sat(osat[1]));

  prod_accum #(.PW(8), .AW(12), .N(1)) u_n1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]), .in_prod(ip[2]),
    .out_valid(vld[2]), .out_ready(ordy[2]), .out_sum(sum2), .out_sat(osat[2]));

  always_comb begin
    obs_sum[0] = int'($signed(sum0));
    obs_sum[1] = int'($signed(sum1));
    obs_sum[2] = int'($signed(sum2));
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 3; l++) begin
      acc_m[l] = 0; cnt_m[l] = 0; sum_m[l] = 0;
      sat_m[l] = 1'b0; hold_m[l] = 1'b0; osat_m[l] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string pfx);
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("%s_valid%0d", pfx, l), int'(vld[l]), int'(hold_m[l]));
      chk($sformatf("%s_ready%0d", pfx, l), int'(rdy[l]), int'(!hold_m[l]));
      chk($sformatf("%s_sum%0d", pfx, l), obs_sum[l], sum_m[l]);
      chk($sformatf("%s_sat%0d", pfx, l), int'(osat[l]), int'(osat_m[l]));
    end
  endtask

  // One clock: inputs already set; model advances on the same edge as the DUTs.
  task automatic step();
    bit take[3];
    bit give[3];
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("pre_ready%0d", l), int'(rdy[l]), int'(!hold_m[l]));
      take[l] = iv[l] && !hold_m[l];
      give[l] = hold_m[l] && ordy[l];
    end
    @(posedge clk);
    for (int l = 0; l < 3; l++) begin
      int s;
      int mx;
      int mn;
      if (give[l]) begin
        hold_m[l] = 1'b0; acc_m[l] = 0; cnt_m[l] = 0; sat_m[l] = 1'b0;
      end else if (take[l]) begin
        mx = (1 <<< (aw_l[l] - 1)) - 1;
        mn = -(1 <<< (aw_l[l] - 1));
        s  = acc_m[l] + int'($signed(ip[l]));
        if (s > mx) begin s = mx; sat_m[l] = 1'b1; end
        else if (s < mn) begin s = mn; sat_m[l] = 1'b1; end
        acc_m[l] = s;
        cnt_m[l]++;
        if (cnt_m[l] == n_l[l]) begin
          hold_m[l] = 1'b1;
          sum_m[l]  = s;
          osat_m[l] = sat_m[l];
        end
      end
    end
    #1;
    check_outputs("post");
  endtask

  // Offer cnt products on lane l until all are taken (optionally with bubbles).
  task automatic feed(input int l, input int p[4], input int cnt, input bit bubble, input bit rd);
    int i = 0;
    int budget = 0;
    bit tog = 1'b0;
    bit took;
    while (i < cnt && budget < 64) begin
      if (bubble && tog) begin
        iv[l] = 1'b0;
        ip[l] = 8'($urandom);
      end else begin
        iv[l] = 1'b1;
        ip[l] = 8'(p[i]);
      end
      ordy[l] = rd;
      took = iv[l] && !hold_m[l];
      step();
      if (took) i++;
      tog = ~tog;
      budget++;
    end
    if (i < cnt) chk("feed_timeout", i, cnt);
    iv[l] = 1'b0;
  endtask

  initial begin
    for (int l = 0; l < 3; l++) begin
      iv[l] = 1'b0; ip[l] = 8'h00; ordy[l] = 1'b1;
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // continuous sum with out_ready high
    feed(0, '{15, -15, 20, 7}, 4, 1'b0, 1'b1);
    chk("t1_valid", int'(vld[0]), 1);
    chk("t1_sum", obs_sum[0], 27);
    chk("t1_sat", int'(osat[0]), 0);
    step();
    chk("t1_ready_back", int'(rdy[0]), 1);

    // output stall backpressures the input
    feed(0, '{9, 9, 9, 9}, 4, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      iv[0] = 1'b1; ip[0] = 8'd9; ordy[0] = 1'b0;
      step();
      chk("t2_stall_ready", int'(rdy[0]), 0);
      chk("t2_stall_sum", obs_sum[0], 36);
    end
    ordy[0] = 1'b1;
    step();
    feed(0, '{9, 9, 9, 9}, 4, 1'b0, 1'b1);
    chk("t2_sum", obs_sum[0], 36);

    // saturation and clear on AW=9
    feed(1, '{127, 127, 127, 127}, 4, 1'b0, 1'b1);
    chk("t3_pos_sum", obs_sum[1], 255);
    chk("t3_pos_sat", int'(osat[1]), 1);
    feed(1, '{-128, -128, -128, -128}, 4, 1'b0, 1'b1);
    chk("t3_neg_sum", obs_sum[1], -256);
    chk("t3_neg_sat", int'(osat[1]), 1);
    feed(1, '{1, 1, 1, 1}, 4, 1'b0, 1'b1);
    chk("t3_clr_sum", obs_sum[1], 4);
    chk("t3_clr_sat", int'(osat[1]), 0);

    // N=1 with the most negative product
    feed(2, '{-128, 0, 0, 0}, 1, 1'b0, 1'b1);
    chk("t4_valid", int'(vld[2]), 1);
    chk("t4_sum", int'(sum2), int'(12'hF80));

    // asynchronous reset mid-accumulation
    step();
    feed(0, '{50, 60, 0, 0}, 2, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", int'(vld[0]), 0);
    chk("t5_rst_ready", int'(rdy[0]), 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    feed(0, '{1, 2, 3, 4}, 4, 1'b0, 1'b1);
    chk("t5_sum", obs_sum[0], 10);

    // bubbles on the input
    step();
    feed(0, '{5, -3, 2, 1}, 4, 1'b1, 1'b1);
    chk("t6_sum", obs_sum[0], 5);

    // random traffic on all three configurations
    for (int c = 0; c < 800; c++) begin
      for (int l = 0; l < 3; l++) begin
        iv[l]   = ($urandom_range(0, 3) != 0);
        ip[l]   = 8'($urandom);
        ordy[l] = ($urandom_range(0, 2) != 0);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
